// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin arbiter sharing one memory rd/wr port among
// NUM_REQ requesters, with burst hold and an in-order read-return tag FIFO.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/wr/addr/    : per-requester request bundle (packed slices)
//   req_wr_data
//   req_ack               : combinational accept strobe (one-hot or zero)
//   rd_valid, rd_data     : registered read return routed to issuer
//   mem_wr_rdy/mem_rd_rdy : memory port readiness
//   mem_wr_*/mem_rd_*     : registered one-cycle issue to memory
//   mem_rd_data_valid,    : in-order returned read words
//   mem_rd_data
//   tag_full              : outstanding reads == TAG_DEPTH
//   err_unexp_rd          : sticky, read returned with no outstanding tag
module mem_port_arb #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 8,
    parameter int HOLD_MAX  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wr_data,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [NUM_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    input  logic                        mem_wr_rdy,
    input  logic                        mem_rd_rdy,
    output logic                        mem_wr_en,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_wr_addr,
    output logic [ADDR_W-1:0]           mem_rd_addr,
    output logic [DATA_W-1:0]           mem_wr_data,
    input  logic                        mem_rd_data_valid,
    input  logic [DATA_W-1:0]           mem_rd_data,
    output logic                        tag_full,
    output logic                        err_unexp_rd
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW   = PW + 1;
    localparam int HW   = $clog2(HOLD_MAX + 1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [IDXW-1:0] r_owner, w_owner_nxt;
    logic [IDXW-1:0] r_last, w_last_nxt;
    logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
    logic [IDXW-1:0] w_sel, w_grant;
    logic            w_hit, w_keep, w_accept, w_acc_wr;
    logic [NUM_REQ-1:0] w_elig;

    logic [IDXW-1:0] r_tag [TAG_DEPTH];
    logic [PW-1:0]   r_wp, r_rp;
    logic [CW-1:0]   r_cnt;
    logic            w_push, w_pop;

    assign tag_full = (r_cnt == CW'(TAG_DEPTH));

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_valid[i] &
                        (req_wr[i] ? mem_wr_rdy : (mem_rd_rdy & ~tag_full));
        end
    end

    // Search starts one past the base, so the base itself is tried last.
    always_comb begin
        logic [IDXW-1:0] w_base;
        logic [IDXW-1:0] w_idx;
        w_hit  = 1'b0;
        w_sel  = '0;
        w_idx  = '0;
        w_base = (r_state == S_HOLD) ? r_owner : r_last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDXW'((int'(w_base) + k) % NUM_REQ);
            if (!w_hit && w_elig[w_idx]) begin
                w_hit = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    assign w_keep = (r_state == S_HOLD) && w_elig[r_owner] &&
                    (r_hold_cnt < HW'(HOLD_MAX));

    // Next-state process
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold_cnt;
        w_accept    = 1'b0;
        w_grant     = r_owner;
        unique case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_accept    = 1'b1;
                    w_grant     = w_sel;
                    w_owner_nxt = w_sel;
                    w_hold_nxt  = HW'(1);
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_keep) begin
                    w_accept   = 1'b1;
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end else if (w_hit) begin
                    w_accept    = 1'b1;
                    w_grant     = w_sel;
                    w_owner_nxt = w_sel;
                    w_hold_nxt  = HW'(1);
                    w_last_nxt  = r_owner;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_owner;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output process
    always_comb begin
        req_ack = '0;
        if (w_accept && !reset) begin
            req_ack[w_grant] = 1'b1;
        end
    end

    assign w_acc_wr = req_wr[w_grant];
    assign w_push   = w_accept & ~w_acc_wr;
    assign w_pop    = mem_rd_data_valid & (r_cnt != '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_last     <= IDXW'(NUM_REQ - 1);
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Memory issue, one cycle after accept; addr/data hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_rd_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= w_accept & w_acc_wr;
            mem_rd_en <= w_push;
            if (w_accept && w_acc_wr) begin
                mem_wr_addr <= req_addr[w_grant*ADDR_W +: ADDR_W];
                mem_wr_data <= req_wr_data[w_grant*DATA_W +: DATA_W];
            end
            if (w_push) begin
                mem_rd_addr <= req_addr[w_grant*ADDR_W +: ADDR_W];
            end
        end
    end

    // Tag FIFO and read-return routing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            rd_valid     <= '0;
            rd_data      <= '0;
            err_unexp_rd <= 1'b0;
        end else begin
            rd_valid <= '0;
            if (w_push) begin
                r_tag[r_wp] <= w_grant;
                r_wp        <= r_wp + PW'(1);
            end
            if (w_pop) begin
                rd_valid[r_tag[r_rp]] <= 1'b1;
                rd_data               <= mem_rd_data;
                r_rp                  <= r_rp + PW'(1);
            end
            if (mem_rd_data_valid && r_cnt == '0) begin
                err_unexp_rd <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed self-checking bench for mem_port_arb.
// Default parameters: 4 requesters, 24b addr, 32b data, 8 tags, hold 16.
module tb_mem_port_arb;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid, req_wr, req_ack, rd_valid;
    logic [95:0]  req_addr;
    logic [127:0] req_wr_data;
    logic [31:0]  rd_data, mem_wr_data, mem_rd_data;
    logic         mem_wr_rdy, mem_rd_rdy, mem_wr_en, mem_rd_en;
    logic [23:0]  mem_wr_addr, mem_rd_addr;
    logic         mem_rd_data_valid, tag_full, err_unexp_rd;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arb dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wr_data(req_wr_data),
        .req_ack(req_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_wr_rdy(mem_wr_rdy), .mem_rd_rdy(mem_rd_rdy),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_data(mem_rd_data),
        .tag_full(tag_full), .err_unexp_rd(err_unexp_rd)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdv"}, 32'(rd_valid), 0);
        chk({tag, "_rdd"}, rd_data, 0);
        chk({tag, "_wen"}, 32'(mem_wr_en), 0);
        chk({tag, "_ren"}, 32'(mem_rd_en), 0);
        chk({tag, "_wad"}, 32'(mem_wr_addr), 0);
        chk({tag, "_rad"}, 32'(mem_rd_addr), 0);
        chk({tag, "_wdt"}, mem_wr_data, 0);
        chk({tag, "_full"}, 32'(tag_full), 0);
        chk({tag, "_err"}, 32'(err_unexp_rd), 0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_wr = '0;
        req_addr = '0; req_wr_data = '0;
        mem_wr_rdy = 1'b0; mem_rd_rdy = 1'b0;
        mem_rd_data_valid = 1'b0; mem_rd_data = '0;
        tick; tick;
        chk("rst_ack", 32'(req_ack), 0);
        chk_all_zero("rst");
        reset = 1'b0;

        // 1: all four writing, hold of 16 then rotation, no bubbles
        for (int i = 0; i < 4; i++) begin
            req_addr[i*24 +: 24]    = 24'h100 + 24'(i);
            req_wr_data[i*32 +: 32] = 32'hD0 + 32'(i);
        end
        req_valid = 4'hF; req_wr = 4'hF;
        mem_wr_rdy = 1'b1; mem_rd_rdy = 1'b1;
        #1;
        for (int c = 0; c < 80; c++) begin
            chk("t1_ack", 32'(req_ack), 32'(1) << ((c / 16) % 4));
            tick;
            chk("t1_wen", 32'(mem_wr_en), 1);
            chk("t1_wad", 32'(mem_wr_addr), 32'h100 + 32'((c / 16) % 4));
        end
        req_valid = '0;
        #1 chk("t1_idle_ack", 32'(req_ack), 0);
        tick;
        chk("t1_idle_wen", 32'(mem_wr_en), 0);

        // 2: single write from requester 2
        req_addr[2*24 +: 24]    = 24'h000123;
        req_wr_data[2*32 +: 32] = 32'h00FFFFFF;
        req_valid = 4'b0100; req_wr = 4'b0100;
        #1 chk("t2_ack", 32'(req_ack), 32'b0100);
        tick;
        req_valid = '0;
        chk("t2_wen", 32'(mem_wr_en), 1);
        chk("t2_wad", 32'(mem_wr_addr), 32'h123);
        chk("t2_wdt", mem_wr_data, 32'h00FFFFFF);
        chk("t2_ren", 32'(mem_rd_en), 0);
        tick;
        chk("t2_wen_off", 32'(mem_wr_en), 0);
        chk("t2_wad_hold", 32'(mem_wr_addr), 32'h123);

        // 3: eight reads fill the tag FIFO; writes still accepted
        req_addr[1*24 +: 24] = 24'h000200;
        req_valid = 4'b0010; req_wr = 4'b0000;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_rack", 32'(req_ack), 32'b0010);
            tick;
            chk("t3_ren", 32'(mem_rd_en), 1);
            chk("t3_rad", 32'(mem_rd_addr), 32'h200);
            chk("t3_full", 32'(tag_full), (i == 7) ? 1 : 0);
        end
        req_valid = 4'b1010; req_wr = 4'b1000;
        #1 chk("t3_wr_ack", 32'(req_ack), 32'b1000);
        tick;
        chk("t3_wen", 32'(mem_wr_en), 1);
        chk("t3_ren_off", 32'(mem_rd_en), 0);
        chk("t3_full_hold", 32'(tag_full), 1);
        chk("t3_wr_ack2", 32'(req_ack), 32'b1000);
        tick;
        req_valid = 4'b0010; req_wr = 4'b0000;
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'h55;
        #1 chk("t3_blocked", 32'(req_ack), 0);
        tick;
        req_valid = '0;
        chk("t3_full_clr", 32'(tag_full), 0);
        chk("t3_rdv", 32'(rd_valid), 32'b0010);
        chk("t3_rdd", rd_data, 32'h55);
        for (int k = 0; k < 7; k++) begin
            mem_rd_data = 32'h60 + 32'(k);
            tick;
            chk("t3_drain_v", 32'(rd_valid), 32'b0010);
            chk("t3_drain_d", rd_data, 32'h60 + 32'(k));
        end
        mem_rd_data_valid = 1'b0;
        tick;
        chk("t3_rdv_off", 32'(rd_valid), 0);
        chk("t3_err", 32'(err_unexp_rd), 0);

        // 4: interleaved reads 0,3,3,0 routed back in order
        req_addr[0*24 +: 24] = 24'h000300;
        req_addr[3*24 +: 24] = 24'h000333;
        req_valid = 4'b0001;
        #1 chk("t4_ack0", 32'(req_ack), 32'b0001);
        tick;
        chk("t4_rad0", 32'(mem_rd_addr), 32'h300);
        req_valid = 4'b1000;
        #1 chk("t4_ack1", 32'(req_ack), 32'b1000);
        tick;
        chk("t4_rad1", 32'(mem_rd_addr), 32'h333);
        chk("t4_ack2", 32'(req_ack), 32'b1000);
        tick;
        req_valid = 4'b0001;
        #1 chk("t4_ack3", 32'(req_ack), 32'b0001);
        tick;
        req_valid = '0;
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'hA;
        tick;
        chk("t4_v_a", 32'(rd_valid), 32'b0001);
        chk("t4_d_a", rd_data, 32'hA);
        mem_rd_data = 32'hB;
        tick;
        chk("t4_v_b", 32'(rd_valid), 32'b1000);
        chk("t4_d_b", rd_data, 32'hB);
        mem_rd_data = 32'hC;
        tick;
        chk("t4_v_c", 32'(rd_valid), 32'b1000);
        chk("t4_d_c", rd_data, 32'hC);
        mem_rd_data = 32'hD;
        tick;
        chk("t4_v_d", 32'(rd_valid), 32'b0001);
        chk("t4_d_d", rd_data, 32'hD);
        mem_rd_data_valid = 1'b0;
        tick;
        chk("t4_v_off", 32'(rd_valid), 0);

        // 5: stalled write owner loses hold to a pending read
        req_addr[1*24 +: 24]    = 24'h000400;
        req_wr_data[1*32 +: 32] = 32'h44;
        req_addr[2*24 +: 24]    = 24'h000500;
        req_valid = 4'b0110; req_wr = 4'b0010;
        #1 chk("t5_ack_own", 32'(req_ack), 32'b0010);
        tick;
        chk("t5_wen", 32'(mem_wr_en), 1);
        chk("t5_ack_own2", 32'(req_ack), 32'b0010);
        tick;
        mem_wr_rdy = 1'b0;
        #1 chk("t5_ack_rot", 32'(req_ack), 32'b0100);
        tick;
        req_valid = '0; mem_wr_rdy = 1'b1;
        chk("t5_ren", 32'(mem_rd_en), 1);
        chk("t5_wen_off", 32'(mem_wr_en), 0);
        chk("t5_rad", 32'(mem_rd_addr), 32'h500);
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'h77;
        tick;
        chk("t5_rdv", 32'(rd_valid), 32'b0100);
        chk("t5_rdd", rd_data, 32'h77);
        mem_rd_data_valid = 1'b0;
        tick;

        // 6: unexpected return, then reset mid-burst
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'h99;
        tick;
        mem_rd_data_valid = 1'b0;
        chk("t6_err", 32'(err_unexp_rd), 1);
        chk("t6_rdv", 32'(rd_valid), 0);
        tick;
        chk("t6_err_sticky", 32'(err_unexp_rd), 1);
        chk("t6_rdv2", 32'(rd_valid), 0);
        req_valid = 4'hF; req_wr = 4'hF;
        #1 chk("t6_burst_ack", 32'(req_ack), 32'b1000);
        tick; tick; tick;
        reset = 1'b1;
        #1 chk("t6_rst_ack", 32'(req_ack), 0);
        tick;
        chk_all_zero("t6_rst");
        reset = 1'b0;
        #1 chk("t6_post_ack", 32'(req_ack), 32'b0001);
        tick;
        chk("t6_post_wen", 32'(mem_wr_en), 1);
        chk("t6_post_wad", 32'(mem_wr_addr), 32'h300);
        req_valid = '0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Round-robin arbiter that shares one read/write port of the 4-port external memory interface among NUM_REQ requesters (camera frame writers, display/readback readers).
- Grants one transfer per cycle. A HOLD_MAX burst hold keeps the same owner while it streams, to preserve address locality.
- Tracks outstanding reads in a tag FIFO so each returned read word is routed back to the requester that issued it.
- Sits between the frame buffer controllers and the memory interface port.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 24: word address width.
- DATA_W, 32: data width.
- TAG_DEPTH, 8: maximum outstanding reads; power of 2.
- HOLD_MAX, 16: maximum consecutive accepts granted to one owner before rotation is forced.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_wr_data  in  NUM_REQ*DATA_W  packed write data.
- req_ack  out  NUM_REQ  combinational accept strobe, one-hot or zero.
- rd_valid  out  NUM_REQ  registered, one-hot read-return strobe.
- rd_data  out  DATA_W  registered read data; valid when any rd_valid bit is 1.
- mem_wr_rdy  in  1  memory port can accept a write.
- mem_rd_rdy  in  1  memory port can accept a read.
- mem_wr_en  out  1  write strobe, one cycle.
- mem_rd_en  out  1  read strobe, one cycle.
- mem_wr_addr  out  ADDR_W  write address.
- mem_rd_addr  out  ADDR_W  read address.
- mem_wr_data  out  DATA_W  write data.
- mem_rd_data_valid  in  1  returned read word valid; returns are in order.
- mem_rd_data  in  DATA_W  returned read word.
- tag_full  out  1  outstanding-read count == TAG_DEPTH.
- err_unexp_rd  out  1  sticky flag: a read returned with no outstanding tag.

Behaviour:
- Reset:
  - All outputs 0.
  - state = IDLE; last_owner = NUM_REQ-1, so requester 0 wins first.
  - hold_cnt = 0; tag FIFO empty; err_unexp_rd cleared.
  - Outstanding reads are discarded. The integrator quiesces memory before reset; stray returns afterwards set err_unexp_rd.
- Eligibility: requester i is eligible when req_valid[i] AND (req_wr[i] ? mem_wr_rdy : (mem_rd_rdy AND !tag_full)).
- Handshake:
  - req_ack[i]=1 in the cycle requester i is accepted.
  - The requester holds req_wr/req_addr/req_wr_data stable while req_valid=1 and req_ack=0.
  - The requester may change them the cycle after ack.
  - Dropping req_valid before ack is allowed; nothing is issued.
- FSM IDLE:
  - Round-robin search over eligible requesters, starting at last_owner+1 mod NUM_REQ.
  - On a hit at i: accept i, owner = i, hold_cnt = 1, go to HOLD.
  - No hit: stay IDLE.
- FSM HOLD:
  - If owner is eligible and hold_cnt < HOLD_MAX: accept owner, hold_cnt++.
  - Otherwise round-robin search from owner+1 (wraps to owner last). On a hit at j: accept j, owner = j, hold_cnt = 1, last_owner = previous owner.
  - Otherwise go to IDLE with last_owner = owner.
  - Rotation adds no bubble cycle.
  - A stalled owner (valid but not eligible) loses the hold.
- Issue latency: exactly 1 cycle.
  - On the edge after an accept, mem_wr_en or mem_rd_en = 1 for one cycle, with the captured address (and data for writes).
  - Address/data outputs hold their last value otherwise.
  - At most one accept per cycle; mem_wr_en and mem_rd_en are never both 1.
- Tag FIFO:
  - Read accept pushes the owner index.
  - mem_rd_data_valid pops the head. On the next edge, rd_valid[head]=1 and rd_data = mem_rd_data.
  - Simultaneous push and pop are both honoured; the count is unchanged.
  - Push never occurs when full, because eligibility is gated by tag_full.
  - Pop when empty: err_unexp_rd set (sticky until reset), no rd_valid, pointers unchanged.
- Counters: read/write pointers are log2(TAG_DEPTH) bits and wrap naturally; count is log2(TAG_DEPTH)+1 bits.

Test Plan:
1. Reset, then req_valid=4'b1111, all writes, rdy=1 held, HOLD_MAX=16 -> req 0 acked 16 consecutive cycles, then req 1 for 16, then 2, 3, 0. mem_wr_en high every cycle with no bubble.
2. Req 2 single write (addr 24'h000123, data 32'hFFFFFF) -> req_ack[2] in cycle N; mem_wr_en=1, mem_wr_addr=24'h000123, mem_wr_data=32'hFFFFFF in cycle N+1 only.
3. Req 1 issues 8 reads with mem_rd_data_valid held 0 -> tag_full=1 after the 8th; further read requests are not acked while writes from req 3 still are acked. The first mem_rd_data_valid clears tag_full.
4. Interleaved reads from req 0 and req 3 (order 0,3,3,0), with returns 32'hA,B,C,D -> rd_valid pulses 0001, 1000, 1000, 0001 carrying A, B, C, D, each 1 cycle after its mem_rd_data_valid.
5. Owner 1 streaming; mem_wr_rdy drops while req 2 has a pending read and mem_rd_rdy=1 -> req 2 acked the same cycle, and req 1 loses the hold.
6. mem_rd_data_valid with an empty FIFO -> err_unexp_rd=1 and no rd_valid. Apply reset mid-burst -> all outputs 0 next cycle, and the next grant goes to req 0.
